// File: rtl/ex_mem_lsu.sv
// EX/MEM stage with a req/ack load-store unit; stalls upstream while an access is outstanding.
// Optional misalignment trap is enabled by defining LSU_ALIGN_CHECK_EN.
module ex_mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        stallreq_o,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        align_err_o
);

  localparam logic [7:0] OP_LB  = 8'hE0, OP_LH  = 8'hE1, OP_LW = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4, OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8, OP_SH  = 8'hE9, OP_SW = 8'hEB;

  typedef enum logic {IDLE, BUSY} state_e;

  function automatic logic is_mem(input logic [7:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction

`ifdef LSU_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] a);
    if (op inside {OP_LH, OP_LHU, OP_SH}) return a[0];
    if (op inside {OP_LW, OP_SW})         return |a;
    return 1'b0;
  endfunction
`endif

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [4:0]  wd_q, wd_d;
  logic [4:0]  mem_wd_q, mem_wd_d;
  logic        mem_wreg_q, mem_wreg_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
`ifdef LSU_ALIGN_CHECK_EN
  logic        align_err_q, align_err_d;
`endif

  logic        busy;
  logic        is_store;
  logic [3:0]  sel_raw;
  logic [31:0] wdata_rep;
  logic [31:0] load_data;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign busy     = (state_q == BUSY);
  assign is_store = op_q inside {OP_SB, OP_SH, OP_SW};

  // Lane steering for both directions is derived from the latched op/address only.
  always_comb begin
    byte_v = dbus_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_v = dbus_rdata[{addr_q[1], 4'b0000} +: 16];
    unique case (op_q)
      OP_LB, OP_LBU, OP_SB: begin
        sel_raw   = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{sdata_q[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        sel_raw   = 4'b0011 << {addr_q[1], 1'b0};
        wdata_rep = {2{sdata_q[15:0]}};
      end
      default: begin
        sel_raw   = 4'b1111;
        wdata_rep = sdata_q;
      end
    endcase
    unique case (op_q)
      OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_data = {24'h0, byte_v};
      OP_LH:   load_data = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_data = {16'h0, half_v};
      default: load_data = dbus_rdata;
    endcase
  end

  assign stallreq_o = busy;
  assign dbus_req   = busy;
  assign dbus_we    = busy & is_store;
  assign dbus_sel   = busy ? sel_raw : 4'b0000;
  assign dbus_addr  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dbus_wdata = busy ? wdata_rep : 32'h0;

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    wd_d        = wd_q;
    mem_wd_d    = mem_wd_q;
    mem_wreg_d  = mem_wreg_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LSU_ALIGN_CHECK_EN
    align_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (is_mem(ex_aluop)) begin
          op_d       = ex_aluop;
          addr_d     = ex_mem_addr;
          sdata_d    = ex_reg2;
          wd_d       = ex_wd;
          mem_wreg_d = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
          if (misaligned(ex_aluop, ex_mem_addr[1:0])) align_err_d = 1'b1;
          else                                        state_d     = BUSY;
`else
          state_d    = BUSY;
`endif
        end else begin
          mem_wd_d    = ex_wd;
          mem_wreg_d  = ex_wreg;
          mem_wdata_d = ex_wdata;
        end
      end
      BUSY: begin
        if (dbus_ack) begin
          state_d = IDLE;
          if (is_store) begin
            mem_wreg_d = 1'b0;
          end else begin
            mem_wd_d    = wd_q;
            mem_wreg_d  = 1'b1;
            mem_wdata_d = load_data;
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  // NOTE: every register is cleared by the asynchronous reset, which also abandons an in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= 8'h0;
      addr_q      <= 32'h0;
      sdata_q     <= 32'h0;
      wd_q        <= 5'h0;
      mem_wd_q    <= 5'h0;
      mem_wreg_q  <= 1'b0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      wd_q        <= wd_d;
      mem_wd_q    <= mem_wd_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) align_err_q <= 1'b0;
    else      align_err_q <= align_err_d;
  end
  assign align_err_o = align_err_q;
`else
  assign align_err_o = 1'b0;
`endif

  assign mem_wd    = mem_wd_q;
  assign mem_wreg  = mem_wreg_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ex_mem_lsu.sv
// Self-checking bench for ex_mem_lsu: directed cases plus random traffic against a behavioural model.
module tb_ex_mem_lsu;

  localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4, LHU = 8'hE5;
  localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;
  localparam logic [7:0] ADD = 8'h20, NOP = 8'h00;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_mem_addr, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq_o, dbus_req, dbus_we, dbus_ack, align_err_o;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_sel;

  ex_mem_lsu dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_aluop(ex_aluop),
    .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .stallreq_o(stallreq_o),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_sel(dbus_sel),
    .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .align_err_o(align_err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int op_size(input logic [7:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic int lane_off(input int n, input logic [31:0] a);
    if (n == 1) return int'(a % 4);
    if (n == 2) return (int'(a % 4) >= 2) ? 2 : 0;
    return 0;
  endfunction

  bit          m_busy;
  logic [7:0]  m_op;
  logic [31:0] m_addr, m_data;
  logic [4:0]  m_wd;
  logic [4:0]  e_wd;
  logic        e_wreg, e_valid, e_aerr;
  logic [31:0] e_wdata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_op = 0; m_addr = 0; m_data = 0; m_wd = 0;
      e_wd = 0; e_wreg = 0; e_wdata = 0; e_valid = 1; e_aerr = 0;
    end else begin
      e_aerr = 0;
      if (!m_busy) begin
        int n;
        n = op_size(ex_aluop);
        if (n != 0) begin
          e_wreg  = 0;
          e_valid = 0;
          if (ALIGN_EN && (ex_mem_addr % n) != 0) e_aerr = 1;
          else begin
            m_busy = 1; m_op = ex_aluop; m_addr = ex_mem_addr; m_data = ex_reg2; m_wd = ex_wd;
          end
        end else begin
          e_wd = ex_wd; e_wreg = ex_wreg; e_wdata = ex_wdata; e_valid = 1;
        end
      end else if (dbus_ack) begin
        m_busy = 0;
        if (m_op inside {SB, SH, SW}) e_wreg = 0;
        else begin
          int n, off;
          logic [31:0] v, mask;
          n    = op_size(m_op);
          off  = lane_off(n, m_addr);
          mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1);
          v    = (dbus_rdata >> (8 * off)) & mask;
          if ((m_op == LB || m_op == LH) && v[8 * n - 1]) v = v | ~mask;
          e_wdata = v; e_wd = m_wd; e_wreg = 1; e_valid = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst) begin
      int n, off;
      logic [3:0]  s;
      logic [31:0] w;
      n   = op_size(m_op);
      off = lane_off(n, m_addr);
      s   = 4'b0000;
      w   = 32'h0;
      if (m_busy) begin
        for (int i = 0; i < 4; i++) begin
          if (i >= off && i < off + n) s[i] = 1'b1;
          w[8 * i +: 8] = m_data[8 * (i % n) +: 8];
        end
      end
      check("stallreq", 32'(stallreq_o), 32'(m_busy));
      check("dbus_req", 32'(dbus_req), 32'(m_busy));
      check("dbus_we", 32'(dbus_we), 32'(m_busy && (m_op inside {SB, SH, SW})));
      check("dbus_sel", 32'(dbus_sel), 32'(s));
      check("dbus_addr", dbus_addr, m_busy ? (m_addr & ~32'h3) : 32'h0);
      check("dbus_wdata", dbus_wdata, w);
      check("mem_wreg", 32'(mem_wreg), 32'(e_wreg));
      check("align_err", 32'(align_err_o), 32'(e_aerr));
      if (e_valid) begin
        check("mem_wd", 32'(mem_wd), 32'(e_wd));
        check("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_ex(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
  endtask

  // Issues one memory op at a negedge, acks after `waits` wait cycles, returns at the negedge after the ack edge.
  task automatic access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [4:0] wd, input int waits, input logic [31:0] rd,
                        output int stalls, output logic [3:0] sel, output logic [31:0] baddr,
                        output logic [31:0] bwdata, output logic we);
    set_ex(op, addr, reg2, wd, 1'b1, 32'h0);
    @(negedge clk);
    set_ex(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    sel = dbus_sel; baddr = dbus_addr; bwdata = dbus_wdata; we = dbus_we;
    stalls = 0;
    for (int i = 0; i < waits + 4; i++) begin
      if (!stallreq_o) break;
      stalls++;
      if (stalls == waits + 1) begin dbus_ack = 1'b1; dbus_rdata = rd; end
      @(negedge clk);
      dbus_ack = 1'b0;
    end
  endtask

  int          stalls;
  logic [3:0]  sel, seq;
  logic [31:0] baddr, bwd;
  logic        we;

  initial begin
    rst = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    set_ex(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_mem_wreg", 32'(mem_wreg), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_stall", 32'(stallreq_o), 32'h0);
    check("rst_req", 32'(dbus_req), 32'h0);
    check("rst_aerr", 32'(align_err_o), 32'h0);
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Non-memory ADD.
    set_ex(ADD, 32'h0, 32'h0, 5'd3, 1'b1, 32'h5);
    @(negedge clk);
    check("add_wdata", mem_wdata, 32'h5);
    check("add_wd", 32'(mem_wd), 32'd3);
    check("add_wreg", 32'(mem_wreg), 32'h1);
    check("add_stall", 32'(stallreq_o), 32'h0);

    // LB / LBU at 0x103 with two wait cycles.
    access(LB, 32'h103, 32'h0, 5'd7, 2, 32'h80AA_BBCC, stalls, sel, baddr, bwd, we);
    check("lb_sel", 32'(sel), 32'b1000);
    check("lb_addr", baddr, 32'h100);
    check("lb_stalls", 32'(stalls), 32'd3);
    check("lb_wdata", mem_wdata, 32'hFFFF_FF80);
    check("lb_wreg", 32'(mem_wreg), 32'h1);
    check("lb_wd", 32'(mem_wd), 32'd7);
    access(LBU, 32'h103, 32'h0, 5'd9, 2, 32'h80AA_BBCC, stalls, sel, baddr, bwd, we);
    check("lbu_wdata", mem_wdata, 32'h0000_0080);
    check("lbu_stalls", 32'(stalls), 32'd3);

    // SH at 0x22, zero-wait.
    access(SH, 32'h22, 32'h1234_ABCD, 5'd4, 0, 32'h0, stalls, sel, baddr, bwd, we);
    check("sh_addr", baddr, 32'h20);
    check("sh_sel", 32'(sel), 32'b1100);
    check("sh_wdata", bwd, 32'hABCD_ABCD);
    check("sh_we", 32'(we), 32'h1);
    check("sh_wreg", 32'(mem_wreg), 32'h0);

    // LW then SW back-to-back, zero-wait: stall pattern 1,0,1,0 on successive negedges.
    set_ex(LW, 32'h200, 32'h0, 5'd5, 1'b1, 32'h0);
    @(negedge clk);
    set_ex(SW, 32'h300, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h0);
    seq[3] = stallreq_o; dbus_ack = 1'b1; dbus_rdata = 32'h1357_9BDF;
    @(negedge clk);
    seq[2] = stallreq_o; dbus_ack = 1'b0;
    check("lw_wdata", mem_wdata, 32'h1357_9BDF);
    check("lw_wreg", 32'(mem_wreg), 32'h1);
    @(negedge clk);
    set_ex(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    seq[1] = stallreq_o; dbus_ack = 1'b1;
    check("sw_we", 32'(dbus_we), 32'h1);
    @(negedge clk);
    seq[0] = stallreq_o; dbus_ack = 1'b0;
    check("b2b_stall_seq", 32'(seq), 32'b1010);

    // Reset mid-BUSY, then a stale ack.
    set_ex(LW, 32'h40, 32'h0, 5'd6, 1'b1, 32'h0);
    @(negedge clk);
    set_ex(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    check("pre_rst_req", 32'(dbus_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_req", 32'(dbus_req), 32'h0);
    check("rst_async_stall", 32'(stallreq_o), 32'h0);
    check("rst_async_sel", 32'(dbus_sel), 32'h0);
    check("rst_async_addr", dbus_addr, 32'h0);
    check("rst_async_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dbus_ack = 1'b0;
    check("stale_ack_wreg", 32'(mem_wreg), 32'h0);
    check("stale_ack_stall", 32'(stallreq_o), 32'h0);

`ifdef LSU_ALIGN_CHECK_EN
    set_ex(LW, 32'h101, 32'h0, 5'd2, 1'b1, 32'h0);
    @(negedge clk);
    set_ex(NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    check("mis_aerr", 32'(align_err_o), 32'h1);
    check("mis_req", 32'(dbus_req), 32'h0);
    check("mis_stall", 32'(stallreq_o), 32'h0);
    check("mis_wreg", 32'(mem_wreg), 32'h0);
    @(negedge clk);
    check("mis_aerr_pulse", 32'(align_err_o), 32'h0);
`endif

    // Random traffic; the model checker covers every cycle.
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] op;
      if ($urandom_range(0, 9) < 5) begin
        case ($urandom_range(0, 7))
          0: op = LB;  1: op = LH;  2: op = LW;  3: op = LBU;
          4: op = LHU; 5: op = SB;  6: op = SH;  default: op = SW;
        endcase
      end else begin
        op = 8'($urandom_range(0, 255));
        if (op_size(op) != 0) op = op ^ 8'h10;
      end
      set_ex(op, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
      dbus_ack   = ($urandom_range(0, 2) == 0);
      dbus_rdata = $urandom;
      @(negedge clk);
    end
    dbus_ack = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_mem_lsu.md
# ex_mem_lsu

Pipeline stage directly downstream of `ex`: registers the EX result and performs data-memory loads/stores over a simple req/ack data bus. Its registered outputs feed `mem_wb`. While a memory access is outstanding it requests a pipeline stall, so upstream registers (`id_ex`, `if_id`, `pc_reg`) hold their values.

## Interface
Parameters:
- none; widths follow the codebase buses: `RegBus` 32, `RegAddrBus` 5, `AluOpBus` 8.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ex_wd`  in  5  destination register from `ex`.
- `ex_wreg`  in  1  write-enable from `ex`.
- `ex_wdata`  in  32  ALU result from `ex`.
- `ex_aluop`  in  8  operation code, forwarded from `id_ex`.
- `ex_mem_addr`  in  32  effective address for load/store.
- `ex_reg2`  in  32  store data.
- `mem_wd`  out  5  registered destination register to `mem_wb`.
- `mem_wreg`  out  1  registered write-enable to `mem_wb`.
- `mem_wdata`  out  32  registered result to `mem_wb`.
- `stallreq_o`  out  1  pipeline stall request.
- `dbus_req`  out  1  bus request.
- `dbus_we`  out  1  bus write.
- `dbus_addr`  out  32  word address, with bits [1:0] forced to 0.
- `dbus_sel`  out  4  byte enables; bit i selects byte lane i (bits 8i+7:8i).
- `dbus_wdata`  out  32  write data, replicated into lanes.
- `dbus_rdata`  in  32  read data; valid when `dbus_ack` is high.
- `dbus_ack`  in  1  single-cycle completion strobe.
- `align_err_o`  out  1  misalignment pulse (see Configuration).

## Operation
- Memory ops by `ex_aluop`: LB 8'hE0, LH 8'hE1, LW 8'hE3, LBU 8'hE4, LHU 8'hE5, SB 8'hE8, SH 8'hE9, SW 8'hEB. Every other code is non-memory.
- Byte order is little-endian. Lane selection:
  - byte ops: `dbus_sel = 4'b0001 << addr[1:0]`
  - half ops: `dbus_sel = 4'b0011 << {addr[1],1'b0}`
  - word ops: `dbus_sel = 4'b1111`
- Store data is replicated into lanes: SB uses `{4{b}}`, SH uses `{2{h}}`.
- Loads extract the selected lane. LB and LH sign-extend; LBU and LHU zero-extend.
- FSM has two states, IDLE and BUSY.
  - IDLE, non-memory op: `mem_wd`, `mem_wreg` and `mem_wdata` take the `ex_*` values at the edge.
  - IDLE, memory op: op, address, store data and `ex_wd` are latched internally; `mem_wreg` takes 0 (bubble); state goes to BUSY.
  - BUSY: `dbus_req`=1. `dbus_we`, `dbus_addr`, `dbus_sel` and `dbus_wdata` are driven from the latched values and held stable until ack. Input `ex_*` is ignored.
  - BUSY with `dbus_ack`=1 at an edge: state goes to IDLE.
    - Loads: `mem_wdata` takes the extended data, `mem_wd` takes the latched wd, and `mem_wreg` takes 1.
    - Stores: `mem_wreg` takes 0.
- `stallreq_o` = (state==BUSY), combinational.
- `dbus_req`, `dbus_we` and `dbus_sel` are 0 in IDLE.
- Reset (asynchronous):
  - state goes to IDLE; all outputs and internal registers go to 0.
  - an outstanding access is abandoned and `dbus_req` drops immediately.
  - an ack arriving after reset is ignored.

## Timing
- Non-memory op: 1-cycle latency, throughput 1 per cycle.
- Memory op captured at edge E0:
  - BUSY cycles: from E0 until the edge at which ack is sampled (E0+1+k for k wait cycles).
  - `mem_*` result valid after that ack edge.
  - `stallreq_o` is high for all BUSY cycles, including the ack cycle.
  - The next instruction is captured one edge after the ack edge.
  - Minimum cost of a memory op (zero-wait ack) is 2 cycles.
- Back-to-back memory ops: exactly one IDLE cycle between BUSY periods.
- `dbus_ack` while IDLE is ignored.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined: a misaligned access is one of:
  - LH, LHU or SH with addr[0]=1;
  - LW or SW with addr[1:0]≠0.
- For a misaligned access at capture:
  - no BUSY state and no bus request;
  - `mem_wreg` takes 0;
  - `align_err_o` is a registered 1-cycle pulse;
  - `stallreq_o` stays low.
- `LSU_ALIGN_CHECK_EN` undefined: the address low bits are ignored for half and word ops (treated as aligned: half uses addr[1], word uses lane 0), and `align_err_o` is tied to 0.

## Test plan
- Non-memory stream: ADD result 32'h0000_0005 with wd=3, wreg=1 → next cycle `mem_wdata`=5, `mem_wd`=3, `mem_wreg`=1; `stallreq_o` never high.
- LB at addr 32'h103 with ack after 2 wait cycles and rdata 32'h80AA_BBCC → `dbus_sel`=4'b1000, `stallreq_o` high 3 cycles, `mem_wdata`=32'hFFFF_FF80. Same access as LBU → 32'h0000_0080.
- SH at addr 32'h22 with reg2=32'h1234_ABCD, zero-wait ack → `dbus_addr`=32'h20, `dbus_sel`=4'b1100, `dbus_wdata`=32'hABCD_ABCD, `dbus_we`=1, `mem_wreg`=0.
- LW followed by SW, both zero-wait → each BUSY for 1 cycle, with exactly one IDLE cycle between.
- Reset asserted (low) mid-BUSY → `dbus_req` and all outputs drop to 0 asynchronously; a later ack produces no `mem_wreg` pulse.
- With `LSU_ALIGN_CHECK_EN`: LW at 32'h101 → no `dbus_req`, `align_err_o` 1 for one cycle, `mem_wreg`=0.
